// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | hazard_ctrl_pkg : shared encodings, FSM state type and limits for  |
// |                   the pipeline hazard controller                   |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
package hazard_ctrl_pkg;
   localparam logic [1:0] MEMOP_READ   = 2'b00;
   localparam logic [1:0] MEMOP_WRITE  = 2'b01;
   localparam logic [1:0] MEMOP_NONE   = 2'b11;
   localparam logic [3:0] REG_NONE     = 4'b1111;
   localparam logic [7:0] WAIT_TIMEOUT = 8'd255;
   localparam int         STAT_W       = 16;

   typedef logic [1:0] state_t;
   localparam state_t ST_RUN       = 2'd0;
   localparam state_t ST_MEM_WAIT  = 2'd1;
   localparam state_t ST_LU_BUBBLE = 2'd2;
endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | hazard_ctrl_if : pipeline-status inputs and stage controls of the  |
// |                  hazard controller; STALL_STAT_EN adds counters    |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
interface hazard_ctrl_if;
   logic [3:0] id_rreg1;
   logic [3:0] id_rreg2;
   logic [3:0] ex_wreg;
   logic [1:0] ex_controlmem;
   logic       ex_jump_taken;
   logic [1:0] mem_controlmem;
   logic       mem_on_iram;
   logic       mem_ready;
   logic       pc_keep;
   logic       ifid_keep;
   logic       ifid_clear;
   logic       idex_keep;
   logic       idex_clear;
   logic       exmem_keep;
   logic       timeout_err;
`ifdef STALL_STAT_EN
   logic [15:0] cnt_lu;
   logic [15:0] cnt_st;
   logic [15:0] cnt_flush;
   logic [15:0] cnt_wait;

   modport slave (
      input  id_rreg1, id_rreg2, ex_wreg, ex_controlmem, ex_jump_taken,
             mem_controlmem, mem_on_iram, mem_ready,
      output pc_keep, ifid_keep, ifid_clear, idex_keep, idex_clear,
             exmem_keep, timeout_err, cnt_lu, cnt_st, cnt_flush, cnt_wait
   );
   modport master (
      output id_rreg1, id_rreg2, ex_wreg, ex_controlmem, ex_jump_taken,
             mem_controlmem, mem_on_iram, mem_ready,
      input  pc_keep, ifid_keep, ifid_clear, idex_keep, idex_clear,
             exmem_keep, timeout_err, cnt_lu, cnt_st, cnt_flush, cnt_wait
   );
`else
   modport slave (
      input  id_rreg1, id_rreg2, ex_wreg, ex_controlmem, ex_jump_taken,
             mem_controlmem, mem_on_iram, mem_ready,
      output pc_keep, ifid_keep, ifid_clear, idex_keep, idex_clear,
             exmem_keep, timeout_err
   );
   modport master (
      output id_rreg1, id_rreg2, ex_wreg, ex_controlmem, ex_jump_taken,
             mem_controlmem, mem_on_iram, mem_ready,
      input  pc_keep, ifid_keep, ifid_clear, idex_keep, idex_clear,
             exmem_keep, timeout_err
   );
`endif
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl_detect.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | hazard_detect : combinational load-use, structural and pending     |
// |                 memory-access terms                                |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module hazard_detect
   import hazard_ctrl_pkg::*;
(
   input  logic [3:0] id_rreg1_i,
   input  logic [3:0] id_rreg2_i,
   input  logic [3:0] ex_wreg_i,
   input  logic [1:0] ex_controlmem_i,
   input  logic [1:0] mem_controlmem_i,
   input  logic       mem_on_iram_i,
   output logic       pend_o,
   output logic       lu_o,
   output logic       st_o
);
   logic match1;
   logic match2;

   assign match1 = (id_rreg1_i != REG_NONE) && (id_rreg1_i == ex_wreg_i);
   assign match2 = (id_rreg2_i != REG_NONE) && (id_rreg2_i == ex_wreg_i);
   assign pend_o = (mem_controlmem_i != MEMOP_NONE);
   assign lu_o   = (ex_controlmem_i == MEMOP_READ) && (ex_wreg_i != REG_NONE)
                   && (match1 || match2);
   // A data access to instruction RAM steals the fetch port this cycle.
   assign st_o   = pend_o && mem_on_iram_i;
endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | hazard_ctrl : pipeline stall/flush controller (memory wait, jump   |
// |               flush, structural, load-use); STALL_STAT_EN adds     |
// |               saturating stall-statistics counters                 |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module hazard_ctrl
   import hazard_ctrl_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   hazard_ctrl_if.slave hz_if
);
   state_t     state_q, state_d;
   logic       flush_pend_q, flush_pend_d;
   logic [7:0] wait_cnt_q, wait_cnt_d;
   logic       pend, lu, st;
   logic       freeze, run_eval, do_flush, do_st, do_lu, tmo;

   hazard_detect u_detect (
      .id_rreg1_i       (hz_if.id_rreg1),
      .id_rreg2_i       (hz_if.id_rreg2),
      .ex_wreg_i        (hz_if.ex_wreg),
      .ex_controlmem_i  (hz_if.ex_controlmem),
      .mem_controlmem_i (hz_if.mem_controlmem),
      .mem_on_iram_i    (hz_if.mem_on_iram),
      .pend_o           (pend),
      .lu_o             (lu),
      .st_o             (st)
   );

   always_comb begin
      state_d      = state_q;
      flush_pend_d = flush_pend_q;
      wait_cnt_d   = wait_cnt_q;
      freeze       = 1'b0;
      run_eval     = 1'b0;
      do_flush     = 1'b0;
      do_st        = 1'b0;
      do_lu        = 1'b0;
      tmo          = 1'b0;
      case (state_q)
         ST_MEM_WAIT: begin
            if (hz_if.mem_ready) begin
               run_eval = 1'b1;
               state_d  = ST_RUN;
            end else if (wait_cnt_q == WAIT_TIMEOUT) begin
               tmo      = 1'b1;
               run_eval = 1'b1;
               state_d  = ST_RUN;
            end else begin
               freeze       = 1'b1;
               wait_cnt_d   = wait_cnt_q + 8'd1;
               flush_pend_d = flush_pend_q | hz_if.ex_jump_taken;
            end
         end
         default: begin
            if (pend && !hz_if.mem_ready) begin
               freeze       = 1'b1;
               state_d      = ST_MEM_WAIT;
               wait_cnt_d   = 8'd0;
               flush_pend_d = flush_pend_q | hz_if.ex_jump_taken;
            end else begin
               run_eval = 1'b1;
               state_d  = ST_RUN;
            end
         end
      endcase
      // Unfrozen cycles (including a wait exit) resolve flush > structural > load-use.
      if (run_eval) begin
         flush_pend_d = 1'b0;
         if (hz_if.ex_jump_taken || flush_pend_q) begin
            do_flush = 1'b1;
         end else if (st) begin
            do_st = 1'b1;
         end else if (lu && (state_q != ST_LU_BUBBLE)) begin
            do_lu   = 1'b1;
            state_d = ST_LU_BUBBLE;
         end
      end
   end

   always_comb begin
      hz_if.pc_keep     = 1'b0;
      hz_if.ifid_keep   = 1'b0;
      hz_if.ifid_clear  = 1'b0;
      hz_if.idex_keep   = 1'b0;
      hz_if.idex_clear  = 1'b0;
      hz_if.exmem_keep  = 1'b0;
      hz_if.timeout_err = 1'b0;
      if (rst) begin
         hz_if.pc_keep     = freeze | do_st | do_lu;
         hz_if.ifid_clear  = do_flush | do_st;
         hz_if.idex_clear  = do_flush | do_lu;
         hz_if.ifid_keep   = (freeze | do_lu) & ~hz_if.ifid_clear;
         hz_if.idex_keep   = freeze & ~hz_if.idex_clear;
         hz_if.exmem_keep  = freeze;
         hz_if.timeout_err = tmo;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_RUN;
         flush_pend_q <= 1'b0;
         wait_cnt_q   <= 8'd0;
      end else begin
         state_q      <= state_d;
         flush_pend_q <= flush_pend_d;
         wait_cnt_q   <= wait_cnt_d;
      end
   end

`ifdef STALL_STAT_EN
   logic [STAT_W-1:0] cnt_lu_q, cnt_st_q, cnt_flush_q, cnt_wait_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_lu_q    <= '0;
         cnt_st_q    <= '0;
         cnt_flush_q <= '0;
         cnt_wait_q  <= '0;
      end else begin
         if (do_lu && (cnt_lu_q != '1))       cnt_lu_q    <= cnt_lu_q + 16'd1;
         if (do_st && (cnt_st_q != '1))       cnt_st_q    <= cnt_st_q + 16'd1;
         if (do_flush && (cnt_flush_q != '1)) cnt_flush_q <= cnt_flush_q + 16'd1;
         if (freeze && (cnt_wait_q != '1))    cnt_wait_q  <= cnt_wait_q + 16'd1;
      end
   end

   assign hz_if.cnt_lu    = cnt_lu_q;
   assign hz_if.cnt_st    = cnt_st_q;
   assign hz_if.cnt_flush = cnt_flush_q;
   assign hz_if.cnt_wait  = cnt_wait_q;
`endif
endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_hazard_ctrl : directed self-checking bench for hazard_ctrl      |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_hazard_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   n_frozen;
   logic seen_err;

   hazard_ctrl_if hz ();

   hazard_ctrl dut (
      .clk   (clk),
      .rst   (rst),
      .hz_if (hz)
   );

   always #5 clk = ~clk;

   // {pc_keep, ifid_keep, ifid_clear, idex_keep, idex_clear, exmem_keep, timeout_err}
   function automatic logic [6:0] outs();
      return {hz.pc_keep, hz.ifid_keep, hz.ifid_clear, hz.idex_keep,
              hz.idex_clear, hz.exmem_keep, hz.timeout_err};
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      hz.id_rreg1       = 4'hF;
      hz.id_rreg2       = 4'hF;
      hz.ex_wreg        = 4'hF;
      hz.ex_controlmem  = 2'b11;
      hz.ex_jump_taken  = 1'b0;
      hz.mem_controlmem = 2'b11;
      hz.mem_on_iram    = 1'b0;
      hz.mem_ready      = 1'b1;
   endtask

   initial begin
      idle();
      hz.ex_jump_taken = 1'b1;
      tick(); #1;
      chk("reset_outs", 16'(outs()), 16'h0000);
      idle();
      rst = 1'b1;
      tick(); #1;
      chk("idle", 16'(outs()), 16'h0000);

      // load-use on rreg1, then one suppressed bubble cycle
      hz.ex_controlmem = 2'b00; hz.ex_wreg = 4'd3; hz.id_rreg1 = 4'd3;
      #1 chk("lu_rreg1", 16'(outs()), 16'b1100100);
      tick();
      chk("lu_bubble", 16'(outs()), 16'h0000);
      tick(); idle(); #1;
      chk("lu_after", 16'(outs()), 16'h0000);

      // load-use on rreg2
      hz.ex_controlmem = 2'b00; hz.ex_wreg = 4'd5; hz.id_rreg2 = 4'd5;
      #1 chk("lu_rreg2", 16'(outs()), 16'b1100100);
      tick(); idle(); #1;
      chk("lu2_after", 16'(outs()), 16'h0000);

      // no false hazards
      tick();
      hz.ex_controlmem = 2'b00;
      #1 chk("no_haz_none", 16'(outs()), 16'h0000);
      hz.ex_controlmem = 2'b01; hz.ex_wreg = 4'd3; hz.id_rreg1 = 4'd3;
      #1 chk("no_haz_store", 16'(outs()), 16'h0000);

      // taken jump
      tick(); idle();
      hz.ex_jump_taken = 1'b1;
      #1 chk("jump", 16'(outs()), 16'b0010100);
      tick(); idle(); #1;
      chk("jump_after", 16'(outs()), 16'h0000);

      // structural alone, then structural together with load-use
      hz.mem_controlmem = 2'b00; hz.mem_on_iram = 1'b1;
      #1 chk("st_only", 16'(outs()), 16'b1010000);
      tick();
      hz.mem_controlmem = 2'b01;
      hz.ex_controlmem = 2'b00; hz.ex_wreg = 4'd3; hz.id_rreg1 = 4'd3;
      #1 chk("st_over_lu", 16'(outs()), 16'b1010000);
      tick(); idle(); #1;
      chk("st_after", 16'(outs()), 16'h0000);

      // memory wait of 3 frozen cycles, jump seen in cycle 2, flush on exit
      hz.mem_controlmem = 2'b00; hz.mem_ready = 1'b0;
      #1 chk("wait_c1", 16'(outs()), 16'b1101010);
      tick(); hz.ex_jump_taken = 1'b1;
      #1 chk("wait_c2", 16'(outs()), 16'b1101010);
      tick(); hz.ex_jump_taken = 1'b0;
      #1 chk("wait_c3", 16'(outs()), 16'b1101010);
      tick(); hz.mem_ready = 1'b1;
      #1 chk("wait_exit_flush", 16'(outs()), 16'b0010100);
      tick(); idle(); #1;
      chk("wait_after", 16'(outs()), 16'h0000);

      // timeout: entry cycle + 255 MEM_WAIT cycles frozen, then the pulse
      hz.mem_controlmem = 2'b00; hz.mem_ready = 1'b0;
      n_frozen = 0;
      seen_err = 1'b0;
      #1;
      for (int i = 0; i < 400; i++) begin
         if (hz.timeout_err) begin
            seen_err = 1'b1;
            break;
         end
         if (hz.pc_keep) n_frozen++;
         tick(); #1;
      end
      chk("timeout_seen", 16'(seen_err), 16'h0001);
      chk("timeout_outs", 16'(outs()), 16'b0000001);
      chk("timeout_frozen_cycles", 16'(n_frozen), 16'd256);
      hz.mem_controlmem = 2'b11;
      tick(); #1;
      chk("timeout_after", 16'(outs()), 16'h0000);

      // reset mid-wait: outputs forced low, no timeout pulse
      hz.mem_controlmem = 2'b00; hz.mem_ready = 1'b0;
      tick(); tick();
      #1 chk("wait_before_rst", 16'(outs()), 16'b1101010);
      rst = 1'b0;
      #1 chk("rst_mid_wait", 16'(outs()), 16'h0000);
      tick(); #1;
      chk("rst_held", 16'(outs()), 16'h0000);
      idle();
      rst = 1'b1;
      #1 chk("rst_release", 16'(outs()), 16'h0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  pipeline clock; pipeline registers capture on negedge, this block's state updates on posedge.
REQ-002 SHALL have rst  in  1  reset rst, asynchronous, active-low.
REQ-003 SHALL have id_rreg1, id_rreg2  in  4 each  ID-stage source registers; 4'b1111 means unused.
REQ-004 SHALL have ex_wreg  in  4  ID/EX destination register; 4'b1111 means no write.
REQ-005 SHALL have ex_controlmem  in  2  ID/EX memory op: 00 read, 01 write, 11 none.
REQ-006 SHALL have ex_jump_taken  in  1  EX resolved a taken jump or branch.
REQ-007 SHALL have mem_controlmem  in  2  EX/MEM memory op, same encoding as ex_controlmem.
REQ-008 SHALL have mem_on_iram  in  1  the MEM access targets the instruction RAM.
REQ-009 SHALL have mem_ready  in  1  the memory or serial access completes this cycle.
REQ-010 SHALL have pc_keep, ifid_keep, ifid_clear, idex_keep, idex_clear, exmem_keep  out  1 each  pipeline register controls.
REQ-011 SHALL have timeout_err  out  1  one-cycle pulse when a memory wait is abandoned.

Function
REQ-012 SHALL implement FSM states RUN, MEM_WAIT, LU_BUBBLE, registered on posedge clk.
REQ-013 SHALL drive all outputs combinationally from the current state and inputs, so they are stable before the following negedge.
- Detection terms:
  - pend = mem_controlmem != 11.
  - lu = (ex_controlmem == 00) and (ex_wreg != 1111) and ex_wreg matches an id_rreg that is not 1111.
  - st = pend and mem_on_iram.
REQ-014 SHALL give priority, in RUN: memory wait > flush > structural > load-use.
REQ-015 SHALL, in RUN with pend and !mem_ready, assert pc_keep, ifid_keep, idex_keep and exmem_keep, and go to MEM_WAIT.
REQ-016 SHALL, in MEM_WAIT, hold all four keeps until mem_ready = 1, then go to RUN in the same cycle with the keeps deasserted.
REQ-017 SHALL, on ex_jump_taken while not frozen, assert ifid_clear and idex_clear for exactly one cycle, with pc_keep = 0.
REQ-018 SHALL latch ex_jump_taken seen during MEM_WAIT into flush_pend, and apply the flush on the exit cycle.
REQ-019 SHALL, on st, assert pc_keep and ifid_clear, so the failed fetch becomes a bubble.
REQ-020 SHALL, on lu, assert pc_keep, ifid_keep and idex_clear, then go to LU_BUBBLE.
REQ-021 SHALL, in LU_BUBBLE, suppress load-use detection for one cycle and then return to RUN.
REQ-022 SHALL never assert any keep and the clear of the same register together; clear wins.
REQ-023 SHALL count MEM_WAIT cycles in an 8-bit counter; at 255, pulse timeout_err, drop the keeps and return to RUN.
REQ-024 SHALL clear the wait counter on every MEM_WAIT entry.

Reset
REQ-025 SHALL, while rst = 0: state RUN, flush_pend 0, wait counter 0, all outputs 0.
REQ-026 SHALL abandon a MEM_WAIT on reset mid-wait without asserting timeout_err.

Configuration
REQ-027 SHALL, when STALL_STAT_EN is defined, add outputs:
- cnt_lu, cnt_st, cnt_flush, cnt_wait, each 16 bits;
- each counter saturates and counts the cycles its condition drove the outputs;
- each counter resets to 0.
REQ-028 SHALL, when STALL_STAT_EN is undefined, omit these ports and counters entirely.

Structure
REQ-029 SHALL place in the shared package:
- the memory-op encodings MEMOP_READ, MEMOP_WRITE, MEMOP_NONE;
- REG_NONE = 4'b1111;
- the FSM state type;
- WAIT_TIMEOUT = 255.
REQ-030 SHALL use one sub-module, hazard_detect, holding the combinational lu and st terms.

Verification
REQ-031 Load-use: ex_controlmem=00, ex_wreg=3, id_rreg1=3 -> one cycle of pc_keep, ifid_keep, idex_clear; next cycle, outputs all 0.
REQ-032 No false hazard: ex_wreg=1111, id_rreg1=1111 -> no stall.
REQ-033 Jump: ex_jump_taken=1 -> ifid_clear and idex_clear for 1 cycle; pc_keep=0.
REQ-034 Memory wait: pend, with mem_ready low for 3 cycles and ex_jump_taken pulsed in cycle 2 -> 3 frozen cycles, then flush on exit.
REQ-035 Timeout: mem_ready held 0 -> timeout_err after 255 wait cycles; rst low mid-wait -> outputs 0 and no err.
REQ-036 Structural: st=1 together with lu=1 -> pc_keep and ifid_clear only; idex_clear=0.
